cache_nway_ctrl: RTL and testbench

CACHE_NWAY_CTRL -- requirements
Module: cache_nway_ctrl

---
 rtl/cache_nway_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_cache_nway_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative blocking cache controller: age-based LRU, 8-word block fill, write-through/no-allocate stores.
// Latency: load hit and store complete in the request cycle; a load miss stalls through FILL and COMMIT, then hits.
// Backpressure: stall holds the requester; memory reads are issued one per cycle with in-order returns of any latency.
module cache_nway_ctrl #(
    parameter int WAYS      = 2,
    parameter int SET_BITS  = 6,
    parameter int WORD_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        flush,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int SETS     = 1 << SET_BITS;
    localparam int WORDS    = 1 << WORD_BITS;
    localparam int TAG_LSB  = SET_BITS + WORD_BITS + 1;
    localparam int TAG_BITS = 16 - TAG_LSB;
    localparam int AGE_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_BITS = AGE_BITS;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT, FLUSH} state_t;

    state_t state_q, state_d;
    logic   rst_q;

    // Only valid bits and ages carry reset; tags and data are qualified by valid.
    logic [WAYS-1:0][SETS-1:0]                valid_q;
    logic [SETS-1:0][WAYS-1:0][AGE_BITS-1:0]  age_q;
    logic [TAG_BITS-1:0]                      tag_q  [WAYS][SETS];
    logic [15:0]                              data_q [WAYS][SETS][WORDS];

    logic [TAG_BITS-1:0]  lat_tag;
    logic [SET_BITS-1:0]  lat_set;
    logic [WAY_BITS-1:0]  lat_way;
    logic [WORD_BITS-1:0] issue_cnt, recv_cnt;
    logic                 issue_done;
    logic [SET_BITS-1:0]  flush_cnt;

    logic [TAG_BITS-1:0]  a_tag;
    logic [SET_BITS-1:0]  a_set;
    logic [WORD_BITS-1:0] a_word;
    logic                 unused_bits;

    assign a_tag       = addr[15:TAG_LSB];
    assign a_set       = addr[TAG_LSB-1:WORD_BITS+1];
    assign a_word      = addr[WORD_BITS:1];
    assign unused_bits = addr[0];

    logic                hit;
    logic [WAY_BITS-1:0] hit_way, vict;
    logic                found_inv;

    // Tag compare across ways; victim is the lowest invalid way, else the oldest.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vict      = '0;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][a_set] && tag_q[w][a_set] == a_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!found_inv && !valid_q[w][a_set]) begin
                found_inv = 1'b1;
                vict      = WAY_BITS'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[a_set][w] == AGE_BITS'(WAYS - 1)) vict = WAY_BITS'(w);
            end
        end
    end

    logic                touch_en, store_wr, miss_latch, issue, recv, commit, flush_step;
    logic [SET_BITS-1:0] touch_set;
    logic [WAY_BITS-1:0] touch_way;
    logic [AGE_BITS-1:0] touch_age;
    logic                blank;

    // Outputs are forced quiet during reset and the cycle after it.
    assign blank     = rst | rst_q;
    assign touch_age = age_q[touch_set][touch_way];

    // Next-state, memory command and array update strobes.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rdata      = '0;
        touch_en   = 1'b0;
        touch_set  = a_set;
        touch_way  = hit_way;
        store_wr   = 1'b0;
        miss_latch = 1'b0;
        issue      = 1'b0;
        recv       = 1'b0;
        commit     = 1'b0;
        flush_step = 1'b0;
        if (!blank) begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        stall   = 1'b1;
                        state_d = FLUSH;
                    end else if (req && wr) begin
                        mem_en    = 1'b1;
                        mem_wr    = 1'b1;
                        mem_addr  = addr;
                        mem_wdata = wdata;
                        store_wr  = hit;
                        touch_en  = hit;
                    end else if (req && hit) begin
                        rdata    = data_q[hit_way][a_set][a_word];
                        touch_en = 1'b1;
                    end else if (req) begin
                        stall      = 1'b1;
                        miss_latch = 1'b1;
                        state_d    = FILL;
                    end
                end
                FILL: begin
                    stall = 1'b1;
                    if (!issue_done) begin
                        mem_en   = 1'b1;
                        mem_addr = {lat_tag, lat_set, issue_cnt, 1'b0};
                        issue    = 1'b1;
                    end
                    if (mem_rvalid) begin
                        recv = 1'b1;
                        if (recv_cnt == WORD_BITS'(WORDS - 1)) state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    stall     = 1'b1;
                    commit    = 1'b1;
                    touch_en  = 1'b1;
                    touch_set = lat_set;
                    touch_way = lat_way;
                    state_d   = IDLE;
                end
                FLUSH: begin
                    stall      = 1'b1;
                    flush_step = 1'b1;
                    if (flush_cnt == SET_BITS'(SETS - 1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state, counters, valid bits and ages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rst_q      <= 1'b1;
            lat_tag    <= '0;
            lat_set    <= '0;
            lat_way    <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            issue_done <= 1'b0;
            flush_cnt  <= '0;
            valid_q    <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= AGE_BITS'(w);
        end else begin
            rst_q   <= 1'b0;
            state_q <= state_d;
            if (miss_latch) begin
                lat_tag    <= a_tag;
                lat_set    <= a_set;
                lat_way    <= vict;
                issue_cnt  <= '0;
                recv_cnt   <= '0;
                issue_done <= 1'b0;
            end
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
                if (issue_cnt == WORD_BITS'(WORDS - 1)) issue_done <= 1'b1;
            end
            if (recv) recv_cnt <= recv_cnt + 1'b1;
            if (commit) valid_q[lat_way][lat_set] <= 1'b1;
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_BITS'(w) == touch_way)
                        age_q[touch_set][w] <= '0;
                    else if (age_q[touch_set][w] < touch_age)
                        age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
                end
            end
            if (flush_step) begin
                flush_cnt <= flush_cnt + 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][flush_cnt]  <= 1'b0;
                    age_q[flush_cnt][w]    <= AGE_BITS'(w);
                end
            end
        end
    end

    // Tag and data arrays; the tag is written only once every word has landed.
    always_ff @(posedge clk) begin
        if (recv)     data_q[lat_way][lat_set][recv_cnt] <= mem_rdata;
        if (store_wr) data_q[hit_way][a_set][a_word]     <= wdata;
        if (commit)   tag_q[lat_way][lat_set]            <= lat_tag;
    end
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl with a latency-3 memory model and load-result scoreboard.
// Loads push their expected word when driven and are popped when stall drops.
// Memory content defaults to the word address itself, overlaid by observed stores.
module tb_cache_nway_ctrl;
    logic        clk = 1'b0;
    logic        rst, req, wr, flush, mem_rvalid;
    logic [15:0] addr, wdata, mem_rdata;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic        stall, mem_en, mem_wr;

    always #5 clk = ~clk;

    cache_nway_ctrl #(.WAYS(2), .SET_BITS(6), .WORD_BITS(3)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .flush(flush), .rdata(rdata), .stall(stall), .mem_en(mem_en),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    localparam int LAT = 3;
    // Miss: IDLE cycle + 8 issue cycles whose last return lands LAT cycles later + COMMIT.
    localparam int MISS_STALL = 1 + 7 + LAT + 1 + 1;

    typedef struct {int due; logic [15:0] a;} rd_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          n;
    logic [15:0] rd_log[$];
    logic [31:0] wr_log[$];
    logic [15:0] sb_q[$];
    rd_t         rd_q[$];
    logic [15:0] mem_w [logic [15:0]];

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        logic [15:0] al;
        al = {a[15:1], 1'b0};
        if (mem_w.exists(al)) return mem_w[al];
        return al;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: returns reads in order LAT cycles after issue, records every command.
    initial begin
        rd_t r;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                r          = rd_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = mem_val(r.a);
            end
            @(negedge clk);
            if (mem_en) begin
                if (mem_wr) begin
                    wr_log.push_back({mem_addr, mem_wdata});
                    mem_w[{mem_addr[15:1], 1'b0}] = mem_wdata;
                end else begin
                    rd_log.push_back(mem_addr);
                    rd_q.push_back('{cyc + LAT, mem_addr});
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge with req low.
    task automatic do_load(input logic [15:0] a, input bit miss, input string tag);
        logic [15:0] exp_rd[$];
        int          k;
        req   = 1'b1;
        wr    = 1'b0;
        addr  = a;
        flush = 1'b0;
        sb_q.push_back(mem_val(a));
        rd_log.delete();
        if (miss)
            for (int i = 0; i < 8; i++) exp_rd.push_back({a[15:4], 3'(i), 1'b0});
        k = 0;
        @(negedge clk);
        while (stall && k < 300) begin
            k++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, k, miss ? MISS_STALL : 0);
        check({tag, "_rdata"}, rdata, sb_q.pop_front());
        check({tag, "_nreads"}, rd_log.size(), exp_rd.size());
        foreach (exp_rd[i])
            if (i < rd_log.size()) check({tag, "_fill_addr"}, rd_log[i], exp_rd[i]);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d, input string tag);
        req    = 1'b1;
        wr     = 1'b1;
        addr   = a;
        wdata  = d;
        wr_log.delete();
        rd_log.delete();
        @(negedge clk);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_mem_en"}, mem_en, 1);
        check({tag, "_mem_wr"}, mem_wr, 1);
        check({tag, "_mem_addr"}, mem_addr, a);
        check({tag, "_mem_wdata"}, mem_wdata, d);
        @(posedge clk);
        #1;
        req = 1'b0;
        wr  = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b1;
        wr    = 1'b0;
        addr  = 16'h1234;
        wdata = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", stall, 0);
        check("post_rst_mem_en", mem_en, 0);
        check("post_rst_rdata", rdata, 0);
        @(posedge clk);
        #1;

        // First miss fills 0x1230..0x123E, then the re-lookup hits word 2.
        do_load(16'h1234, 1'b1, "boot_load");
        do_load(16'h1234, 1'b0, "boot_hit");

        // Store hit writes through and updates the line.
        do_store(16'h1234, 16'hBEEF, "store_hit");
        check("store_hit_nwrites", wr_log.size(), 1);
        do_load(16'h1234, 1'b0, "load_after_store");

        // Set 5: fill A and B, touch A, C must evict B.
        do_load(16'h0456, 1'b1, "fill_A");
        do_load(16'h0856, 1'b1, "fill_B");
        do_load(16'h0456, 1'b0, "touch_A");
        do_load(16'h0C56, 1'b1, "fill_C");
        do_load(16'h0456, 1'b0, "A_survives");
        do_load(16'h0850, 1'b1, "B_evicted");

        // Store miss: one write, no allocation.
        do_store(16'h2000, 16'h5555, "store_miss");
        repeat (3) @(posedge clk);
        #1;
        check("store_miss_nwrites", wr_log.size(), 1);
        check("store_miss_nofill", rd_log.size(), 0);
        do_load(16'h2000, 1'b1, "load_after_store_miss");

        // Flush wins over a same-cycle store; the store runs once FLUSH ends.
        flush = 1'b1;
        req   = 1'b1;
        wr    = 1'b1;
        addr  = 16'h3000;
        wdata = 16'h7777;
        wr_log.delete();
        @(negedge clk);
        check("flush_cycle_stall", stall, 1);
        check("flush_cycle_mem_en", mem_en, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("flush_stall_cycles", n, 64);
        check("after_flush_store_en", mem_en, 1);
        check("after_flush_store_addr", mem_addr, 16'h3000);
        @(posedge clk);
        #1;
        req = 1'b0;
        wr  = 1'b0;
        do_load(16'h1234, 1'b1, "flushed_1234");
        do_load(16'h0456, 1'b1, "flushed_A");

        // Reset on the 4th FILL cycle; outstanding reads return as strays.
        req  = 1'b1;
        wr   = 1'b0;
        addr = 16'h4000;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_stall", stall, 0);
        check("abort_rst_mem_en", mem_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        rd_log.delete();
        n = 0;
        while (rd_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("abort_strays_drained", rd_q.size(), 0);
        check("abort_no_reads", rd_log.size(), 0);
        check("abort_stall_idle", stall, 0);
        do_load(16'h1234, 1'b1, "abort_empty_1234");
        do_load(16'h4000, 1'b1, "abort_refill");
        do_load(16'h400E, 1'b0, "abort_refill_hit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
